// File: rtl/fifo_rd_drain_pkg.sv
// rtl/fifo_rd_drain_pkg.sv - shared state encodings and default widths for the FIFO read drain
package fifo_rd_drain_pkg;

  localparam int DEF_DW = 16;
  localparam int DEF_UW = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

endpackage

// File: rtl/fifo_rd_drain_skid.sv
// rtl/fifo_rd_drain_skid.sv - 2-entry register FIFO that absorbs the read latency of the source FIFO
module skid_buf2 #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [1:0]    occ,
  output logic [DW-1:0] head
);

  logic [DW-1:0] e0_q, e0_d;
  logic [DW-1:0] e1_q, e1_d;
  logic [1:0]    occ_q, occ_d;
  logic          pop_ok;

  // e0 is always the head; a simultaneous pop and push keeps FIFO order.
  always_comb begin
    e0_d   = e0_q;
    e1_d   = e1_q;
    occ_d  = occ_q;
    pop_ok = pop & (occ_q != 2'd0);
    case ({push, pop_ok})
      2'b10: begin
        if (occ_q == 2'd0) e0_d = push_data;
        else               e1_d = push_data;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        e0_d  = e1_q;
        occ_d = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          e0_d = push_data;
        end else begin
          e0_d = e1_q;
          e1_d = push_data;
        end
      end
      default: ;
    endcase
  end

  // Entry and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q  <= '0;
      e1_q  <= '0;
      occ_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      occ_q <= occ_d;
    end
  end

  assign occ  = occ_q;
  assign head = e0_q;

endmodule

// File: rtl/fifo_rd_drain.sv
// rtl/fifo_rd_drain.sv - read-side controller: threshold-gated FIFO drain into a valid/ready stream
module fifo_rd_drain
  import fifo_rd_drain_pkg::*;
#(
  parameter int DW     = DEF_DW,
  parameter int UW     = DEF_UW,
  parameter int THRESH = 4,
  parameter int CW     = 32
) (
  input  logic          clk_150,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr_stat,
  output logic          rdreq,
  input  logic [DW-1:0] q,
  input  logic          rdempty,
  input  logic          rdfull,
  input  logic [UW-1:0] rdusedw,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          busy,
  output logic [CW-1:0] word_cnt,
  output logic          rdfull_seen
);

  localparam logic [UW:0] FULL_FILL  = (UW+1)'(2**UW);
  localparam logic [UW:0] THRESH_LVL = (UW+1)'(THRESH);

  state_e        state_q, state_d;
  logic          inflight_q, inflight_d;
  logic [CW-1:0] word_cnt_q, word_cnt_d;
  logic          rdfull_seen_q, rdfull_seen_d;

  logic [UW:0]   fill;
  logic [1:0]    occ;
  logic [1:0]    load;
  logic          hs;

  // rdusedw wraps to 0 at full, so rdfull supplies the top count.
  assign fill = rdfull ? FULL_FILL : {1'b0, rdusedw};
  assign load = occ + {1'b0, inflight_q};
  assign hs   = out_valid & out_ready;

  // Read only when the skid buffer can take the word arriving next cycle.
  assign rdreq = (state_q == ST_RUN) & en & ~rdempty & (load < 2'd2);

  // Next-state logic for the drain FSM.
  always_comb begin
    state_d    = state_q;
    inflight_d = rdreq;
    case (state_q)
      ST_IDLE: if (en) state_d = ST_WAIT;
      ST_WAIT: begin
        if (!en)                       state_d = ST_IDLE;
        else if (fill >= THRESH_LVL)   state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!en)                       state_d = ST_IDLE;
        else if (rdempty && !rdreq)    state_d = ST_WAIT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Delivered-word counter and sticky full flag; clear beats count, set beats clear.
  always_comb begin
    word_cnt_d    = word_cnt_q;
    rdfull_seen_d = rdfull_seen_q;
    if (clr_stat)  word_cnt_d = '0;
    else if (hs)   word_cnt_d = word_cnt_q + CW'(1);
    if (rdfull)        rdfull_seen_d = 1'b1;
    else if (clr_stat) rdfull_seen_d = 1'b0;
  end

  // Control and statistics registers.
  always_ff @(posedge clk_150 or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      inflight_q    <= 1'b0;
      word_cnt_q    <= '0;
      rdfull_seen_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      inflight_q    <= inflight_d;
      word_cnt_q    <= word_cnt_d;
      rdfull_seen_q <= rdfull_seen_d;
    end
  end

  skid_buf2 #(.DW(DW)) u_skid (
    .clk       (clk_150),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data (q),
    .pop       (hs),
    .occ       (occ),
    .head      (out_data)
  );

  assign out_valid   = (occ != 2'd0);
  assign busy        = (state_q != ST_IDLE) | (occ != 2'd0) | inflight_q;
  assign word_cnt    = word_cnt_q;
  assign rdfull_seen = rdfull_seen_q;

endmodule
